// File: rtl/spart_rx_if.sv
// spart_rx_if: processor bus view of the SPART receiver.
// The bus drives IOADDR/IORW, the receiver returns RX_DATA, RDA and FE.
interface spart_rx_if;
   logic [1:0] IOADDR;
   logic       IORW;
   logic [7:0] RX_DATA;
   logic       RDA;
   logic       FE;

   modport master (
      output IOADDR, IORW,
      input  RX_DATA, RDA, FE
   );

   modport slave (
      input  IOADDR, IORW,
      output RX_DATA, RDA, FE
   );
endinterface

// File: rtl/spart_rx.sv
// spart_rx: 16x-oversampled 8N1 serial receiver with bus-readable buffer.
// Optional framing-error flag: define SPART_RX_FRAMING_ERR_EN.
module spart_rx (
   input  logic    clk,
   input  logic    rst,
   input  logic    RxD,
   input  logic    Enable,
   spart_rx_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t     state;
   logic       rx_m;
   logic       rx_s;
   logic [3:0] tick;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic [7:0] rx_buf;
   logic       rda;
   logic       rd;

   assign rd = bus.IORW && (bus.IOADDR == 2'b00);

`ifdef SPART_RX_FRAMING_ERR_EN
   logic fe_r;
   assign bus.FE = fe_r;
`else
   assign bus.FE = 1'b0;
`endif

   assign bus.RX_DATA = rx_buf;
   assign bus.RDA     = rda;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         tick    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         rx_buf  <= '0;
         rda     <= 1'b0;
`ifdef SPART_RX_FRAMING_ERR_EN
         fe_r    <= 1'b0;
`endif
      end else begin
         rx_m <= RxD;
         rx_s <= rx_m;
         // a read clears the flags; a completion below in the same clk wins
         if (rd) begin
            rda <= 1'b0;
`ifdef SPART_RX_FRAMING_ERR_EN
            fe_r <= 1'b0;
`endif
         end
         if (Enable) begin
            unique case (state)
               IDLE: begin
                  if (!rx_s) begin
                     state <= START;
                     tick  <= '0;
                  end
               end
               START: begin
                  if (tick == 4'd7) begin
                     if (!rx_s) begin
                        state   <= DATA;
                        tick    <= '0;
                        bit_cnt <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     tick <= tick + 4'd1;
                  end
               end
               DATA: begin
                  tick <= tick + 4'd1;
                  if (tick == 4'd15) begin
                     shift   <= {rx_s, shift[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7)
                        state <= STOP;
                  end
               end
               STOP: begin
                  tick <= tick + 4'd1;
                  if (tick == 4'd15) begin
                     state <= IDLE;
                     if (rx_s) begin
                        rx_buf <= shift;
                        rda    <= 1'b1;
                     end
`ifdef SPART_RX_FRAMING_ERR_EN
                     else begin
                        fe_r <= 1'b1;
                     end
`endif
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: frame-level reference model of the receiver against spart_rx.
// Enable ticks every 4 clks; line bits last 16 ticks each.
module tb_spart_rx;

   logic clk = 1'b0;
   logic rst;
   logic RxD;
   logic Enable;

   spart_rx_if bus ();

   spart_rx dut (
      .clk    (clk),
      .rst    (rst),
      .RxD    (RxD),
      .Enable (Enable),
      .bus    (bus)
   );

   always #5 clk = ~clk;

`ifdef SPART_RX_FRAMING_ERR_EN
   localparam bit FE_EN = 1'b1;
`else
   localparam bit FE_EN = 1'b0;
`endif

   // frame tick (1-based from start-bit onset) carrying the stop sample:
   // detect at 1, mid start 1+8, then 9 further bit periods of 16
   localparam int STOP_TICK = 1 + 8 + 16 * 9;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_data;
   logic       exp_rda;
   logic       exp_fe;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_rda"}, {31'd0, bus.RDA}, {31'd0, exp_rda});
      chk({tag, "_data"}, {24'd0, bus.RX_DATA}, {24'd0, exp_data});
      chk({tag, "_fe"}, {31'd0, bus.FE}, {31'd0, exp_fe});
   endtask

   function automatic void model_read();
      exp_rda = 1'b0;
      exp_fe  = 1'b0;
   endfunction

   function automatic void model_frame(input logic [7:0] d, input bit stop);
      if (stop) begin
         exp_data = d;
         exp_rda  = 1'b1;
      end else if (FE_EN) begin
         exp_fe = 1'b1;
      end
   endfunction

   function automatic void model_reset();
      exp_data = 8'h00;
      exp_rda  = 1'b0;
      exp_fe   = 1'b0;
   endfunction

   // 3 idle clks then one Enable clk; returns 1 time unit after its edge
   task automatic tick(input bit rd);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      Enable = 1'b1;
      if (rd) begin
         bus.IORW   = 1'b1;
         bus.IOADDR = 2'b00;
      end
      @(posedge clk);
      #1;
      Enable   = 1'b0;
      bus.IORW = 1'b0;
   endtask

   task automatic do_reset();
      RxD = 1'b1;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic bus_op(input logic iorw, input logic [1:0] addr);
      bus.IORW   = iorw;
      bus.IOADDR = addr;
      @(posedge clk);
      #1;
      bus.IORW   = 1'b0;
      bus.IOADDR = 2'b00;
      if (iorw && addr == 2'b00)
         model_read();
      chk_all("busop");
   endtask

   // rst_at: line bit index (0 = start bit) at which to reset, -1 for none
   task automatic send_frame(input logic [7:0] d, input bit stop,
                             input bit rd_cmp, input int rst_at);
      logic [9:0] line;
      bit         ab;
      int         n;
      line = {stop, d, 1'b0};
      ab   = 1'b0;
      for (int b = 0; b < 10; b++) begin
         if (!ab) RxD = line[b];
         for (int k = 0; k < 16; k++) begin
            if (!ab) begin
               n = b * 16 + k + 1;
               if (b == rst_at && k == 4) begin
                  do_reset();
                  ab = 1'b1;
               end else begin
                  tick(n == STOP_TICK && rd_cmp);
                  if (n == STOP_TICK - 1)
                     chk("pre_stop_rda", {31'd0, bus.RDA}, {31'd0, exp_rda});
                  if (n == STOP_TICK) begin
                     if (rd_cmp) model_read();
                     model_frame(d, stop);
                     chk_all("stop_tick");
                  end
               end
            end
         end
      end
      RxD = 1'b1;
      repeat (24) tick(1'b0);
   endtask

   initial begin
      logic [7:0] d;
      rst        = 1'b1;
      RxD        = 1'b1;
      Enable     = 1'b0;
      bus.IORW   = 1'b0;
      bus.IOADDR = 2'b00;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      model_reset();
      chk_all("reset");

      send_frame(8'h5A, 1'b1, 1'b0, -1);
      chk_all("nominal");
      bus_op(1'b0, 2'b00);
      bus_op(1'b1, 2'b01);
      bus_op(1'b1, 2'b00);

      RxD = 1'b0;
      repeat (4) tick(1'b0);
      RxD = 1'b1;
      repeat (24) tick(1'b0);
      chk_all("glitch");

      send_frame(8'h11, 1'b1, 1'b0, -1);
      send_frame(8'hC3, 1'b1, 1'b1, -1);
      chk_all("overrun");

      send_frame(8'hA5, 1'b0, 1'b0, -1);
      chk_all("framing");
      bus_op(1'b1, 2'b00);

      send_frame(8'hFF, 1'b1, 1'b0, 4);
      chk_all("midrst");
      send_frame(8'h3C, 1'b1, 1'b0, -1);
      chk_all("after_rst");
      bus_op(1'b1, 2'b00);

      for (int i = 0; i < 12; i++) begin
         d = 8'($urandom);
         send_frame(d, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, -1);
         if ($urandom_range(0, 1) == 1)
            bus_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have port RxD, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-004 The module SHALL have port Enable, input, 1 bit: one-clk pulse at 16x baud rate from the baud generator.
REQ-005 The module SHALL have port IOADDR, input, 2 bits: bus register address; 2'b00 selects the data register.
REQ-006 The module SHALL have port IORW, input, 1 bit: bus direction; 1 is read, 0 is write.
REQ-007 The module SHALL have port RX_DATA, output, 8 bits: last received byte (Receive_Buffer).
REQ-008 The module SHALL have port RDA, output, 1 bit: receive data available.
REQ-009 The module SHALL have port FE, output, 1 bit: framing error flag (see Configuration).

Function
REQ-010 RxD SHALL pass through a 2-flop synchronizer (rx_s) before any use; all line decisions use rx_s.
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP; the tick counter is 4 bits, the bit counter 3 bits; logic advances only on clks with Enable=1.
REQ-012 In IDLE, on an Enable tick with rx_s=0, the FSM SHALL enter START with tick counter 0.
REQ-013 In START, on the 8th Enable tick (mid start bit): if rx_s=0, the FSM SHALL enter DATA with tick and bit counters cleared; if rx_s=1 (glitch), it SHALL return to IDLE with no other state change.
REQ-014 In DATA, every 16th Enable tick SHALL shift rx_s into the MSB of an 8-bit shift register (LSB-first line order); after the 8th data sample the FSM SHALL enter STOP.
REQ-015 In STOP, on the 16th Enable tick: if rx_s=1, the shift register SHALL load Receive_Buffer and RDA SHALL be 1 from the next clk; then the FSM SHALL return to IDLE.
REQ-016 If the stop sample is 0, Receive_Buffer and RDA SHALL be unchanged and the FSM SHALL return to IDLE; FE behaviour is per REQ-024/025.
REQ-017 A bus read ({IORW,IOADDR}=3'b100) SHALL clear RDA on the next clk; other addresses and writes SHALL not affect the module.
REQ-018 When a completion (REQ-015) and a read occur in the same clk, the completion SHALL win: RDA=1 and the new byte is in Receive_Buffer.
REQ-019 Overrun: a completion with RDA already 1 SHALL overwrite Receive_Buffer; RDA stays 1.
REQ-020 RX_DATA SHALL always reflect Receive_Buffer, stable between completions.
REQ-021 Receive latency SHALL be exactly 1 clk from the Enable tick of the stop sample to RDA=1.

Reset
REQ-022 With rst=1 at a clk edge: FSM=IDLE; counters=0; synchronizer flops=1; shift register=8'h00; Receive_Buffer=8'h00; RDA=0; FE=0.
REQ-023 rst asserted mid-frame SHALL abort the frame, and the partial byte SHALL never appear on RX_DATA.

Configuration
REQ-024 With macro SPART_RX_FRAMING_ERR_EN defined: a 0 stop sample SHALL set FE=1 on the next clk; FE SHALL stay 1 until a bus read at IOADDR 2'b00 or rst; a valid completion SHALL not clear FE.
REQ-025 Without SPART_RX_FRAMING_ERR_EN: FE SHALL be tied to 0, and a bad-stop frame SHALL be discarded silently.

Verification
REQ-026 A bench SHALL check reset: rst for 2 clks, RxD=1 -> RDA=0, RX_DATA=8'h00, FE=0.
REQ-027 A bench SHALL check a nominal receive: frame 0x5A at 16 Enables/bit -> RX_DATA=8'h5A, RDA=1 exactly 1 clk after the stop-sample tick; a read at addr 00 -> RDA=0 next clk.
REQ-028 A bench SHALL check glitch rejection: RxD low for 4 Enable ticks, then high -> FSM back to IDLE, RDA stays 0, no byte loaded.
REQ-029 A bench SHALL check overrun and simultaneity: send 0x11 unread, then 0xC3 -> RX_DATA=8'hC3, RDA=1; a read asserted in the same clk as completion -> RDA remains 1.
REQ-030 A bench SHALL check framing: frame 0xA5 with stop bit 0 -> RX_DATA unchanged, RDA unchanged; FE=1 if SPART_RX_FRAMING_ERR_EN is defined, else FE=0.
REQ-031 A bench SHALL check mid-frame reset: rst during data bit 3 of 0xFF -> RDA=0, RX_DATA=8'h00; the next frame 0x3C is received correctly.
